// File: rtl/jt1943_objline.sv
// jt1943_objline - double-buffered object line buffer.
//
// The object draw stage streams palette-resolved pixels (posx, new_pxl) for
// the next line into the draw bank while the display bank is scanned out by
// H and erased behind the beam. The banks swap on each line end (LHBL fall).
//
// Ports:
//   clk      24 MHz system clock
//   rst      asynchronous active-high reset
//   cen6     6 MHz pixel enable, one clk wide, at least 4 clk apart
//   LHBL     horizontal blank, active-low; a falling edge marks line end
//   posx     draw x; posx[8]=1 means off-line, nothing is written
//   new_pxl  pixel to draw at posx
//   H        display read address
//   obj_pxl  object pixel towards the colour mixer
//   busy     high while the post-reset clear runs
module jt1943_objline #(
  parameter int         AW     = 8,
  parameter int         DW     = 8,
  parameter logic [3:0] TRANSP = 4'hf
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen6,
  input  logic          LHBL,
  input  logic [8:0]    posx,
  input  logic [DW-1:0] new_pxl,
  input  logic [AW-1:0] H,
  output logic [DW-1:0] obj_pxl,
  output logic          busy
);

  localparam int            DEPTH = 1 << AW;
  localparam logic [DW-1:0] BLANK = {DW{1'b1}};

  typedef enum logic { CLEAR, RUN } state_t;

  state_t        state, next_state;
  logic [AW-1:0] clr_addr;
  logic [1:0]    phase;
  logic          bank;      // bank currently being drawn; the other is displayed
  logic          rmw_bank;  // bank snapshot owned by the in-flight read-modify-write
  logic          lhbl_l;
  logic [8:0]    posx_l;
  logic [DW-1:0] pxl_l;
  logic [AW-1:0] h_l;

  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];
  logic [DW-1:0] rd0, rd1;
  logic [AW-1:0] raddr0, raddr1, waddr0, waddr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          we0, we1;
  logic [DW-1:0] draw_rd, disp_rd;
  logic          draw_we;

  assign busy = (state == CLEAR);

  // Clear walks every address once, then the buffer runs forever.
  always_comb begin
    next_state = state;
    if (state == CLEAR && clr_addr == {AW{1'b1}})
      next_state = RUN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= next_state;
  end

  // Pixel pipeline: cen6 latches the request and issues both reads, phase 1
  // waits for the synchronous RAM, phase 2 commits both writes and obj_pxl.
  // The bank snapshot taken at cen6 keeps a request on its pre-swap bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_addr <= '0;
      phase    <= 2'd0;
      bank     <= 1'b0;
      rmw_bank <= 1'b0;
      lhbl_l   <= 1'b0;
      posx_l   <= 9'd0;
      pxl_l    <= '0;
      h_l      <= '0;
      obj_pxl  <= BLANK;
    end else if (state == CLEAR) begin
      clr_addr <= clr_addr + 1'b1;
      phase    <= 2'd0;
      obj_pxl  <= BLANK;
    end else if (cen6) begin
      phase    <= 2'd1;
      posx_l   <= posx;
      pxl_l    <= new_pxl;
      h_l      <= H;
      rmw_bank <= bank;
      lhbl_l   <= LHBL;
      if (lhbl_l && !LHBL)
        bank <= ~bank;
    end else if (phase == 2'd1) begin
      phase <= 2'd2;
    end else if (phase == 2'd2) begin
      phase   <= 2'd0;
      obj_pxl <= disp_rd;
    end
  end

  // Draw reads at posx in the draw bank, display reads at H in the other one.
  always_comb begin
    raddr0 = bank ? H : posx[AW-1:0];
    raddr1 = bank ? posx[AW-1:0] : H;
  end

  assign draw_rd = rmw_bank ? rd1 : rd0;
  assign disp_rd = rmw_bank ? rd0 : rd1;

  // Only fill a still-transparent slot, so the first opaque object wins.
  assign draw_we = (phase == 2'd2) && !posx_l[8] &&
                   (pxl_l[3:0] != TRANSP) && (draw_rd[3:0] == TRANSP);

  // Write port steering: clear both banks, or draw into one and erase the other.
  always_comb begin
    we0    = 1'b0;
    we1    = 1'b0;
    waddr0 = clr_addr;
    waddr1 = clr_addr;
    wdata0 = BLANK;
    wdata1 = BLANK;
    if (state == CLEAR) begin
      we0 = 1'b1;
      we1 = 1'b1;
    end else if (phase == 2'd2) begin
      if (!rmw_bank) begin
        we0    = draw_we;
        waddr0 = posx_l[AW-1:0];
        wdata0 = pxl_l;
        we1    = 1'b1;
        waddr1 = h_l;
      end else begin
        we1    = draw_we;
        waddr1 = posx_l[AW-1:0];
        wdata1 = pxl_l;
        we0    = 1'b1;
        waddr0 = h_l;
      end
    end
  end

  // Plain synchronous RAMs; reads only happen on accepted pixel slots.
  always_ff @(posedge clk) begin
    if (we0) mem0[waddr0] <= wdata0;
    if (we1) mem1[waddr1] <= wdata1;
    if (cen6 && state == RUN) begin
      rd0 <= mem0[raddr0];
      rd1 <= mem1[raddr1];
    end
  end

endmodule

// File: tb/tb_jt1943_objline.sv
module tb_jt1943_objline;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen6 = 1'b0;
  logic       LHBL = 1'b1;
  logic [8:0] posx = 9'h100;
  logic [7:0] new_pxl = 8'h00;
  logic [7:0] H = 8'h00;
  logic [7:0] obj_pxl;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       lhbl;
    logic [8:0] posx;
    logic [7:0] pxl;
    logic [7:0] h;
    logic [7:0] expv;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  jt1943_objline dut (
    .clk     (clk),
    .rst     (rst),
    .cen6    (cen6),
    .LHBL    (LHBL),
    .posx    (posx),
    .new_pxl (new_pxl),
    .H       (H),
    .obj_pxl (obj_pxl),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // One comparison; every check in the bench funnels through here.
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic void addVec(input logic lhbl, input logic [8:0] px,
                                 input logic [7:0] pxl, input logic [7:0] h,
                                 input logic [7:0] expv);
    vec_t v;
    v.lhbl = lhbl; v.posx = px; v.pxl = pxl; v.h = h; v.expv = expv;
    vecs.push_back(v);
  endfunction

  // Pop the oldest expected pixel and compare against the DUT output.
  task automatic checkOutput();
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("obj_pxl", {24'd0, obj_pxl}, {24'd0, e});
    end
  endtask

  // One pixel slot: cen6 on a negedge, output sampled 3 clk later, next slot
  // starts one clk after that so cen6 pulses are 4 clk apart.
  task automatic applyStimulus(input logic lhbl, input logic [8:0] px,
                               input logic [7:0] pxl, input logic [7:0] h,
                               input logic [7:0] expv);
    @(negedge clk);
    cen6 = 1'b1; LHBL = lhbl; posx = px; new_pxl = pxl; H = h;
    exp_q.push_back(expv);
    @(negedge clk);
    cen6 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // Time the clear after a reset release and check outputs while it runs.
  task automatic waitClear();
    int cycles;
    check("busy_in_reset", {31'd0, busy}, 32'd1);
    check("obj_in_reset", {24'd0, obj_pxl}, 32'hff);
    @(negedge clk);
    rst = 1'b0;
    cycles = 0;
    while (busy && cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == 100) begin
        check("busy_mid_clear", {31'd0, busy}, 32'd1);
        check("obj_mid_clear", {24'd0, obj_pxl}, 32'hff);
      end
    end
    check("clear_length", cycles, 32'd256);
  endtask

  // Scan a whole line with no drawing; display bank must be all-ones.
  task automatic scanLine();
    for (int i = 0; i < 256; i++)
      applyStimulus(1'b1, 9'h100, 8'h00, 8'(i), 8'hff);
  endtask

  initial begin
    // Draws go into bank 1 while bank 0 is shown (after the first swap).
    addVec(1, 9'h00a, 8'h23, 8'h30, 8'hff);
    addVec(1, 9'h014, 8'h45, 8'h31, 8'hff);
    addVec(1, 9'h014, 8'h67, 8'h32, 8'hff);
    addVec(1, 9'h015, 8'h4f, 8'h33, 8'hff);
    addVec(1, 9'h015, 8'h31, 8'h34, 8'hff);
    addVec(1, 9'h114, 8'h12, 8'h35, 8'hff);
    addVec(1, 9'h11e, 8'h12, 8'h36, 8'hff);
    addVec(1, 9'h0ff, 8'h70, 8'h37, 8'hff);
    addVec(1, 9'h000, 8'h80, 8'h38, 8'hff);
    addVec(0, 9'h005, 8'h5a, 8'h39, 8'hff);  // swap on same cen6 as a draw
    // Bank 1 now shown, bank 0 drawn.
    addVec(1, 9'h100, 8'h00, 8'h0a, 8'h23);
    addVec(1, 9'h100, 8'h00, 8'h0b, 8'hff);
    addVec(1, 9'h100, 8'h00, 8'h14, 8'h45);
    addVec(1, 9'h100, 8'h00, 8'h15, 8'h31);
    addVec(1, 9'h100, 8'h00, 8'h1e, 8'hff);
    addVec(1, 9'h100, 8'h00, 8'h05, 8'h5a);
    addVec(1, 9'h100, 8'h00, 8'hff, 8'h70);
    addVec(1, 9'h100, 8'h00, 8'h00, 8'h80);
    addVec(1, 9'h040, 8'h9c, 8'h06, 8'hff);
    addVec(0, 9'h100, 8'h00, 8'h0a, 8'hff);  // already erased behind the beam
    // Bank 0 shown.
    addVec(1, 9'h100, 8'h00, 8'h40, 8'h9c);
    addVec(1, 9'h100, 8'h00, 8'h14, 8'hff);
    addVec(1, 9'h100, 8'h00, 8'h0a, 8'hff);
    addVec(0, 9'h100, 8'h00, 8'h41, 8'hff);
    // Bank 1 shown again, all erased without redraw.
    addVec(1, 9'h100, 8'h00, 8'h14, 8'hff);
    addVec(1, 9'h100, 8'h00, 8'h05, 8'hff);
    addVec(1, 9'h100, 8'h00, 8'h15, 8'hff);
    addVec(1, 9'h100, 8'h00, 8'h00, 8'hff);

    $display("[TB] reset and clear");
    repeat (3) @(negedge clk);
    waitClear();

    $display("[TB] post-reset scan of both banks");
    scanLine();
    applyStimulus(1'b0, 9'h100, 8'h00, 8'h00, 8'hff);
    scanLine();

    $display("[TB] draw, display, priority and swap vectors");
    foreach (vecs[i])
      applyStimulus(vecs[i].lhbl, vecs[i].posx, vecs[i].pxl, vecs[i].h, vecs[i].expv);

    $display("[TB] reset between phase 1 and phase 2");
    @(negedge clk);
    cen6 = 1'b1; LHBL = 1'b1; posx = 9'h01e; new_pxl = 8'h11; H = 8'h00;
    @(negedge clk);
    cen6 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    waitClear();
    scanLine();
    applyStimulus(1'b0, 9'h100, 8'h00, 8'h00, 8'hff);
    scanLine();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
